// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the byte-lane mask / store-data replication helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   function automatic logic [3:0] f_byteMask(input logic [2:0] funct3,
                                             input logic [1:0] offset);
      case (funct3)
         F3_B, F3_BU: return 4'b0001 << offset;
         F3_H, F3_HU: return 4'b0011 << offset;
         default:     return 4'b1111;
      endcase
   endfunction

   // Memory picks the right lane via the write mask, so copies go to every lane.
   function automatic logic [31:0] f_replicate(input logic [2:0]  funct3,
                                               input logic [31:0] data);
      case (funct3)
         F3_B:    return {4{data[7:0]}};
         F3_H:    return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

   function automatic logic f_isLegal(input logic       write,
                                      input logic [2:0] funct3);
      if (write)
         return funct3 inside {F3_B, F3_H, F3_W};
      else
         return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   function automatic logic f_isAligned(input logic [2:0] funct3,
                                        input logic [1:0] offset);
      case (funct3[1:0])
         2'b01:   return (offset[0] == 1'b0);
         2'b10:   return (offset == 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side load/store handshake plus the data-memory bus of the LSU.
interface lsu_ctrl_if;

   logic        ls_valid;
   logic        ls_write;
   logic [2:0]  ls_funct3;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_stall;
   logic        ls_done;
   logic        ls_err;

   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;

   modport slave (
      input  ls_valid, ls_write, ls_funct3, ls_addr, ls_wdata,
      input  dmem_rdata, dmem_resp,
      output ls_stall, ls_done, ls_err,
      output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata
   );

   modport master (
      output ls_valid, ls_write, ls_funct3, ls_addr, ls_wdata,
      output dmem_rdata, dmem_resp,
      input  ls_stall, ls_done, ls_err,
      input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata
   );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the read word by the byte offset and
// produces every sign/zero-extended load width at once.
module lsu_load_align (
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_offset,
   output logic [31:0] o_lb,
   output logic [31:0] o_lh,
   output logic [31:0] o_lw,
   output logic [31:0] o_lbu,
   output logic [31:0] o_lhu
);

   logic [31:0] w_shifted;

   assign w_shifted = i_rdata >> {i_offset, 3'b000};

   assign o_lb  = {{24{w_shifted[7]}},  w_shifted[7:0]};
   assign o_lbu = {24'h000000,          w_shifted[7:0]};
   assign o_lh  = {{16{w_shifted[15]}}, w_shifted[15:0]};
   assign o_lhu = {16'h0000,            w_shifted[15:0]};
   assign o_lw  = i_rdata;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one data-memory transaction per request, stalling the core
// until completion, and registered load vectors for the bit-sliced mem_mux.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   lsu_ctrl_if.slave   bus,
   output logic [31:0] lb,
   output logic [31:0] lh,
   output logic [31:0] lw,
   output logic [31:0] lbu,
   output logic [31:0] lhu
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_t  r_state;
   lsu_state_t  w_stateNext;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_funct3;
   logic        r_write;
   logic        r_err;
   logic [7:0]  r_cnt;

   logic        w_errNext;
   logic        w_accept;
   logic        w_capture;

   logic [31:0] r_lb;
   logic [31:0] r_lh;
   logic [31:0] r_lw;
   logic [31:0] r_lbu;
   logic [31:0] r_lhu;

   logic [31:0] w_lb;
   logic [31:0] w_lh;
   logic [31:0] w_lw;
   logic [31:0] w_lbu;
   logic [31:0] w_lhu;

   logic [3:0]  w_mask;

   lsu_load_align u_align (
      .i_rdata  (bus.dmem_rdata),
      .i_offset (r_addr[1:0]),
      .o_lb     (w_lb),
      .o_lh     (w_lh),
      .o_lw     (w_lw),
      .o_lbu    (w_lbu),
      .o_lhu    (w_lhu)
   );

   // Next-state decode; rejected requests skip memory and go straight to DONE.
   always_comb begin
      w_stateNext = r_state;
      w_errNext   = 1'b0;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.ls_valid) begin
               if (f_isLegal(bus.ls_write, bus.ls_funct3) &&
                   f_isAligned(bus.ls_funct3, bus.ls_addr[1:0])) begin
                  w_accept    = 1'b1;
                  w_stateNext = BUSY;
               end else begin
                  w_errNext   = 1'b1;
                  w_stateNext = DONE;
               end
            end
         end
         BUSY: begin
            if (bus.dmem_resp) begin
               w_capture   = 1'b1;
               w_stateNext = DONE;
            end else if (r_cnt == TO_LAST) begin
               w_errNext   = 1'b1;
               w_stateNext = DONE;
            end
         end
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_funct3 <= '0;
         r_write  <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_stateNext;
         r_err   <= w_errNext;
         if (w_accept) begin
            r_addr   <= bus.ls_addr;
            r_wdata  <= bus.ls_wdata;
            r_funct3 <= bus.ls_funct3;
            r_write  <= bus.ls_write;
            r_cnt    <= '0;
         end else if (r_state == BUSY && !bus.dmem_resp) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   // All five widths are captured together; the core selects by funct3 downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lb  <= '0;
         r_lh  <= '0;
         r_lw  <= '0;
         r_lbu <= '0;
         r_lhu <= '0;
      end else if (w_capture && !r_write) begin
         r_lb  <= w_lb;
         r_lh  <= w_lh;
         r_lw  <= w_lw;
         r_lbu <= w_lbu;
         r_lhu <= w_lhu;
      end
   end

   assign w_mask = f_byteMask(r_funct3, r_addr[1:0]);

   assign bus.ls_stall   = (r_state == IDLE && bus.ls_valid) || (r_state == BUSY);
   assign bus.ls_done    = (r_state == DONE);
   assign bus.ls_err     = (r_state == DONE) && r_err;
   assign bus.dmem_addr  = {r_addr[31:2], 2'b00};
   assign bus.dmem_rmask = (r_state == BUSY && !r_write) ? w_mask : 4'b0000;
   assign bus.dmem_wmask = (r_state == BUSY &&  r_write) ? w_mask : 4'b0000;
   assign bus.dmem_wdata = f_replicate(r_funct3, r_wdata);

   assign lb  = r_lb;
   assign lh  = r_lh;
   assign lw  = r_lw;
   assign lbu = r_lbu;
   assign lhu = r_lhu;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard-driven bench for lsu_ctrl: each request pushes its expected
// completion, and a negedge monitor pops and compares on every ls_done.
module tb_lsu_ctrl;
   import lsu_pkg::*;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lb, lh, lw, lbu, lhu;

   lsu_ctrl_if bus ();

   lsu_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .lb    (lb),
      .lh    (lh),
      .lw    (lw),
      .lbu   (lbu),
      .lhu   (lhu)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] lb, lh, lw, lbu, lhu;
   } exp_t;

   exp_t        sbQueue[$];
   exp_t        monEntry;
   int          vectorCount = 0;
   int          missCount   = 0;
   logic [31:0] mdlLb = 0, mdlLh = 0, mdlLw = 0, mdlLbu = 0, mdlLhu = 0;

   int          obsDoneCycle, obsBusyCycles, obsStallBad;
   logic        obsMaskSeen;
   logic [3:0]  obsRmask, obsWmask;
   logic [31:0] obsAddr, obsWdata;

   // Every completion pulse is matched against the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.ls_done === 1'b1) begin
         vectorCount++;
         if (sbQueue.size() == 0) begin
            missCount++;
            $display("[TB] FAIL sb_unexpected_done: ls_done=1 with no pending request");
         end else begin
            monEntry = sbQueue.pop_front();
            if (bus.ls_err !== monEntry.err) begin
               missCount++;
               $display("[TB] FAIL sb_err: got %b expected %b", bus.ls_err, monEntry.err);
            end
            vectorCount++;
            if ({lb, lh, lw, lbu, lhu} !== {monEntry.lb, monEntry.lh, monEntry.lw, monEntry.lbu, monEntry.lhu}) begin
               missCount++;
               $display("[TB] FAIL sb_vectors: got lb=%h lh=%h lw=%h lbu=%h lhu=%h expected lb=%h lh=%h lw=%h lbu=%h lhu=%h",
                        lb, lh, lw, lbu, lhu, monEntry.lb, monEntry.lh, monEntry.lw, monEntry.lbu, monEntry.lhu);
            end
         end
      end
   end

   task automatic idleCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic runTxn(input logic write, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input logic giveResp);
      exp_t        e;
      logic        legal, aligned, done;
      logic [7:0]  b;
      logic [15:0] h;
      int          cyc, busyIdx;
      legal   = write ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                      : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      aligned = (f3[1:0] == 2'b01) ? (addr[0] == 1'b0) :
                (f3[1:0] == 2'b10) ? (addr[1:0] == 2'b00) : 1'b1;
      if (legal && aligned && giveResp && !write) begin
         case (addr[1:0])
            2'd0:    begin b = rdata[7:0];   h = rdata[15:0];          end
            2'd1:    begin b = rdata[15:8];  h = rdata[23:8];          end
            2'd2:    begin b = rdata[23:16]; h = rdata[31:16];         end
            default: begin b = rdata[31:24]; h = {8'h00, rdata[31:24]}; end
         endcase
         mdlLb  = {{24{b[7]}}, b};
         mdlLbu = {24'd0, b};
         mdlLh  = {{16{h[15]}}, h};
         mdlLhu = {16'd0, h};
         mdlLw  = rdata;
      end
      e.err = !(legal && aligned && giveResp);
      e.lb  = mdlLb;  e.lh  = mdlLh;  e.lw = mdlLw;
      e.lbu = mdlLbu; e.lhu = mdlLhu;
      sbQueue.push_back(e);

      bus.ls_valid  = 1'b1;
      bus.ls_write  = write;
      bus.ls_funct3 = f3;
      bus.ls_addr   = addr;
      bus.ls_wdata  = wdata;
      cyc = 1; busyIdx = 0; done = 1'b0;
      obsDoneCycle = 0; obsBusyCycles = 0; obsStallBad = 0; obsMaskSeen = 1'b0;
      obsRmask = 4'd0; obsWmask = 4'd0; obsAddr = 32'd0; obsWdata = 32'd0;
      while (!done && cyc < 40) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (bus.ls_stall !== !bus.ls_done) obsStallBad++;
         if ((bus.dmem_rmask | bus.dmem_wmask) != 4'd0) begin
            if (!obsMaskSeen) begin
               obsRmask = bus.dmem_rmask;
               obsWmask = bus.dmem_wmask;
               obsAddr  = bus.dmem_addr;
               obsWdata = bus.dmem_wdata;
            end
            obsMaskSeen = 1'b1;
            obsBusyCycles++;
            if (giveResp && busyIdx == waits) begin
               bus.dmem_resp  = 1'b1;
               bus.dmem_rdata = rdata;
            end else begin
               bus.dmem_resp  = 1'b0;
               bus.dmem_rdata = $urandom;
            end
            busyIdx++;
         end else begin
            bus.dmem_resp = 1'b0;
         end
         if (bus.ls_done === 1'b1) begin
            done         = 1'b1;
            obsDoneCycle = cyc;
            bus.ls_valid = 1'b0;
         end
      end
      if (!done) begin
         vectorCount++;
         missCount++;
         $display("[TB] FAIL txn_timeout: no ls_done within %0d cycles for addr %h", cyc, addr);
         bus.ls_valid  = 1'b0;
         bus.dmem_resp = 1'b0;
         void'(sbQueue.pop_back());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.ls_valid = 1'b0; bus.ls_write = 1'b0; bus.ls_funct3 = 3'd0;
      bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0; bus.dmem_rdata = 32'd0; bus.dmem_resp = 1'b0;
      idleCycle();
      idleCycle();
      vectorCount++;
      if ({bus.ls_stall, bus.ls_done, bus.ls_err} !== 3'b000) begin
         missCount++;
         $display("[TB] FAIL reset_status: got %b expected 000", {bus.ls_stall, bus.ls_done, bus.ls_err});
      end
      vectorCount++;
      if ({bus.dmem_rmask, bus.dmem_wmask} !== 8'h00) begin
         missCount++;
         $display("[TB] FAIL reset_masks: got %h expected 00", {bus.dmem_rmask, bus.dmem_wmask});
      end
      vectorCount++;
      if ({bus.dmem_addr, bus.dmem_wdata} !== 64'd0) begin
         missCount++;
         $display("[TB] FAIL reset_bus: got addr=%h wdata=%h expected 0", bus.dmem_addr, bus.dmem_wdata);
      end
      vectorCount++;
      if ({lb, lh, lw, lbu, lhu} !== 160'd0) begin
         missCount++;
         $display("[TB] FAIL reset_vectors: got lb=%h lw=%h lhu=%h expected 0", lb, lw, lhu);
      end
      rst_n = 1'b1;
      idleCycle();
      vectorCount++;
      if (bus.ls_done !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL reset_release_done: got %b expected 0", bus.ls_done);
      end
   endtask

   task automatic test_lb();
      idleCycle();
      runTxn(1'b0, F3_B, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 1'b1);
      vectorCount++;
      if (obsDoneCycle !== 3) begin
         missCount++;
         $display("[TB] FAIL lb_latency: got cycle %0d expected 3", obsDoneCycle);
      end
      vectorCount++;
      if ({obsRmask, obsWmask} !== {4'b1000, 4'b0000}) begin
         missCount++;
         $display("[TB] FAIL lb_masks: got r=%b w=%b expected r=1000 w=0000", obsRmask, obsWmask);
      end
      vectorCount++;
      if (obsAddr !== 32'h0000_1000) begin
         missCount++;
         $display("[TB] FAIL lb_addr: got %h expected 00001000", obsAddr);
      end
      vectorCount++;
      if ({lb, lbu} !== {32'hFFFF_FF80, 32'h0000_0080}) begin
         missCount++;
         $display("[TB] FAIL lb_values: got lb=%h lbu=%h expected ffffff80 00000080", lb, lbu);
      end
   endtask

   task automatic test_sh();
      idleCycle();
      runTxn(1'b1, F3_H, 32'h0000_2002, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 1'b1);
      vectorCount++;
      if ({obsWmask, obsRmask} !== {4'b1100, 4'b0000}) begin
         missCount++;
         $display("[TB] FAIL sh_masks: got w=%b r=%b expected w=1100 r=0000", obsWmask, obsRmask);
      end
      vectorCount++;
      if ({obsAddr, obsWdata} !== {32'h0000_2000, 32'hBEEF_BEEF}) begin
         missCount++;
         $display("[TB] FAIL sh_bus: got addr=%h wdata=%h expected 00002000 beefbeef", obsAddr, obsWdata);
      end
      vectorCount++;
      if ({lb, lw} !== {32'hFFFF_FF80, 32'h80FF_1234}) begin
         missCount++;
         $display("[TB] FAIL sh_vectors_held: got lb=%h lw=%h expected ffffff80 80ff1234", lb, lw);
      end
      idleCycle();
      runTxn(1'b1, F3_B, 32'h0000_2103, 32'h1234_56EF, 32'd0, 1, 1'b1);
      vectorCount++;
      if ({obsWmask, obsWdata} !== {4'b1000, 32'hEFEF_EFEF}) begin
         missCount++;
         $display("[TB] FAIL sb_lane: got w=%b wdata=%h expected 1000 efefefef", obsWmask, obsWdata);
      end
   endtask

   task automatic test_misaligned();
      idleCycle();
      runTxn(1'b0, F3_W, 32'h0000_3001, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
      vectorCount++;
      if (obsMaskSeen !== 1'b0 || obsDoneCycle !== 2) begin
         missCount++;
         $display("[TB] FAIL lw_misaligned: got maskSeen=%b doneCycle=%0d expected 0 2", obsMaskSeen, obsDoneCycle);
      end
      idleCycle();
      runTxn(1'b0, 3'b011, 32'h0000_3000, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
      vectorCount++;
      if (obsMaskSeen !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL illegal_load: got maskSeen=%b expected 0", obsMaskSeen);
      end
      idleCycle();
      runTxn(1'b1, F3_H, 32'h0000_3001, 32'hAAAA_AAAA, 32'd0, 0, 1'b1);
      vectorCount++;
      if (obsMaskSeen !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL sh_misaligned: got maskSeen=%b expected 0", obsMaskSeen);
      end
      idleCycle();
      runTxn(1'b1, F3_BU, 32'h0000_3000, 32'hAAAA_AAAA, 32'd0, 0, 1'b1);
      vectorCount++;
      if (obsMaskSeen !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL illegal_store: got maskSeen=%b expected 0", obsMaskSeen);
      end
   endtask

   task automatic test_offsets();
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [3:0]  expMask;
      for (int i = 0; i < 10; i++) begin
         case (i)
            0, 1, 2, 3: f3 = (i % 2 == 0) ? F3_B : F3_BU;
            4, 5:       f3 = F3_H;
            6, 7:       f3 = F3_HU;
            default:    f3 = F3_W;
         endcase
         addr    = 32'h0000_6000 + 32'(i * 16) + ((i < 4) ? 32'(i) : (i < 8) ? 32'((i % 2) * 2) : 32'd0);
         expMask = (i < 4) ? (4'b0001 << addr[1:0]) : (i < 8) ? (4'b0011 << addr[1:0]) : 4'b1111;
         idleCycle();
         runTxn(1'b0, f3, addr, 32'd0, $urandom, i % 3, 1'b1);
         vectorCount++;
         if (obsRmask !== expMask) begin
            missCount++;
            $display("[TB] FAIL offset_rmask[%0d]: got %b expected %b", i, obsRmask, expMask);
         end
      end
   endtask

   task automatic test_timeout();
      idleCycle();
      runTxn(1'b0, F3_HU, 32'h0000_4002, 32'd0, 32'd0, 0, 1'b0);
      vectorCount++;
      if (obsBusyCycles !== TIMEOUT || obsDoneCycle !== TIMEOUT + 2) begin
         missCount++;
         $display("[TB] FAIL timeout_len: got busy=%0d done=%0d expected %0d %0d",
                  obsBusyCycles, obsDoneCycle, TIMEOUT, TIMEOUT + 2);
      end
      vectorCount++;
      if (obsRmask !== 4'b1100) begin
         missCount++;
         $display("[TB] FAIL timeout_rmask: got %b expected 1100", obsRmask);
      end
      bus.dmem_resp  = 1'b1;
      bus.dmem_rdata = 32'hFFFF_FFFF;
      idleCycle();
      bus.dmem_resp  = 1'b0;
      idleCycle();
      vectorCount++;
      if ({bus.ls_done, bus.ls_stall, bus.dmem_rmask} !== 6'd0 || lw !== mdlLw) begin
         missCount++;
         $display("[TB] FAIL late_resp: got done=%b stall=%b rmask=%b lw=%h expected 0 0 0000 %h",
                  bus.ls_done, bus.ls_stall, bus.dmem_rmask, lw, mdlLw);
      end
   endtask

   task automatic test_reset_busy();
      idleCycle();
      bus.ls_valid  = 1'b1;
      bus.ls_write  = 1'b0;
      bus.ls_funct3 = F3_W;
      bus.ls_addr   = 32'h0000_5000;
      idleCycle();
      vectorCount++;
      if (bus.dmem_rmask !== 4'b1111) begin
         missCount++;
         $display("[TB] FAIL rstbusy_pre: got rmask=%b expected 1111", bus.dmem_rmask);
      end
      #2 rst_n = 1'b0;
      mdlLb = 0; mdlLh = 0; mdlLw = 0; mdlLbu = 0; mdlLhu = 0;
      #1;
      vectorCount++;
      if ({bus.dmem_rmask, bus.dmem_wmask} !== 8'h00) begin
         missCount++;
         $display("[TB] FAIL rstbusy_masks: got %h expected 00", {bus.dmem_rmask, bus.dmem_wmask});
      end
      bus.ls_valid = 1'b0;
      #1;
      vectorCount++;
      if (bus.ls_stall !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL rstbusy_idle: got stall=%b expected 0", bus.ls_stall);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idleCycle();
      vectorCount++;
      if (bus.ls_done !== 1'b0 || lw !== 32'd0) begin
         missCount++;
         $display("[TB] FAIL rstbusy_nodone: got done=%b lw=%h expected 0 00000000", bus.ls_done, lw);
      end
      runTxn(1'b0, F3_W, 32'h0000_5000, 32'd0, 32'hCAFE_F00D, 1, 1'b1);
      vectorCount++;
      if (obsDoneCycle !== 4 || lw !== 32'hCAFE_F00D) begin
         missCount++;
         $display("[TB] FAIL rstbusy_fresh: got done=%0d lw=%h expected 4 cafef00d", obsDoneCycle, lw);
      end
   endtask

   task automatic test_back_to_back();
      int done1, stallBad1;
      idleCycle();
      runTxn(1'b0, F3_W, 32'h0000_0010, 32'd0, 32'h0123_4567, 2, 1'b1);
      done1     = obsDoneCycle;
      stallBad1 = obsStallBad;
      runTxn(1'b0, F3_H, 32'h0000_0012, 32'd0, 32'h89AB_CDEF, 2, 1'b1);
      vectorCount++;
      if (done1 !== 5 || obsDoneCycle !== 6) begin
         missCount++;
         $display("[TB] FAIL b2b_latency: got %0d/%0d expected 5/6", done1, obsDoneCycle);
      end
      vectorCount++;
      if (stallBad1 !== 0 || obsStallBad !== 0) begin
         missCount++;
         $display("[TB] FAIL b2b_stall: got bad=%0d/%0d expected 0/0", stallBad1, obsStallBad);
      end
      vectorCount++;
      if ({lh, lhu} !== {32'hFFFF_89AB, 32'h0000_89AB}) begin
         missCount++;
         $display("[TB] FAIL b2b_lh: got lh=%h lhu=%h expected ffff89ab 000089ab", lh, lhu);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_misaligned();
      test_offsets();
      test_timeout();
      test_reset_busy();
      test_back_to_back();
      idleCycle();
      idleCycle();
      vectorCount++;
      if (sbQueue.size() != 0) begin
         missCount++;
         $display("[TB] FAIL sb_drain: got %0d pending expected 0", sbQueue.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
